id_stage_pipe: RTL and testbench
================================

# id_stage_pipe

Parametrised, handshaked Y86 decode stage with an output pipeline register. Each cycle it takes one fetched instruction and its PC. It splits out icode/ifun/rA/rB, extracts valC, computes valP, drives register-file source IDs, and captures the operands read back. It also classifies instruction status and halts further intake after HALT or an invalid instruction. It sits between fetch and execute and replaces the purely combinational decoder.

## Interface
- WORD_W, 32, data word width; multiple of 8, ≥16
- PC_W, 16, PC width; valP wraps modulo 2^PC_W
- INST_W, 16+WORD_W, instruction window width; byte0 at [INST_W-1:INST_W-8], later bytes below it
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset; rst==0 at a rising edge resets the block
- flush_i  in  1  kill the held instruction and leave HALTED
- in_valid  in  1  pc_i/inst_i valid
- in_ready  out  1  stage accepts this cycle
- pc_i  in  PC_W  PC of the instruction
- inst_i  in  INST_W  instruction bytes
- srcA_o, srcB_o  out  4  register-file read IDs (combinational from inst_i); 0xF = none
- valA_i, valB_i  in  WORD_W  register-file read data for srcA_o/srcB_o, same cycle
- out_valid  out  1  output register holds an instruction
- out_ready  in  1  execute consumes this cycle
- icode_o, ifun_o, rA_o, rB_o  out  4 each  registered fields
- valC_o  out  WORD_W  registered constant
- valP_o  out  PC_W  registered next PC
- valA_o, valB_o  out  WORD_W  registered operands
- stat_o  out  2  0=AOK, 1=HLT, 2=INS
- halted_o  out  1  state==HALTED

## Operation
- Byte k = inst_i byte k. icode = byte0[7:4], ifun = byte0[3:0], rA = byte1[7:4], rB = byte1[3:0]. N = WORD_W/8.
- Lengths:
  - 1: HALT(0), NOP(1), RET(9)
  - 2: RRMOVL/CMOVXX(2), OPL(6), PUSHL(A), POPL(B)
  - 2+N: IRMOVL(3), RMMOVL(4), MRMOVL(5)
  - 1+N: JXX(7), CALL(8)
- valC is little-endian: bytes 2..N+1 for icodes 3/4/5, bytes 1..N for 7/8, else 0.
- rA_o/rB_o take the byte1 nibbles for length-2 and length-(2+N) instructions. Otherwise they are 0xF.
- valP = pc_i + length, truncated to PC_W.
- srcA: rA for 2, 4, 6, A; 4 (%esp) for 9, B; else 0xF.
- srcB: rB for 4, 5, 6; 4 for 8, 9, A, B; else 0xF.
- valA_o/valB_o capture valA_i/valB_i at accept. They are forced to 0 when the corresponding src is 0xF.
- Status INS when any of the following holds:
  - icode > 0xB
  - ifun ≠ 0 for icodes other than 2, 6, 7
  - ifun > 6 for icode 2 or 7
  - ifun > 3 for icode 6
  - a used rA/rB nibble is in 8..0xE
- Otherwise status is HLT for icode 0, else AOK.
- For INS, valP_o = pc_i + 1. All other fields are still registered as decoded.
- FSM states:
  - RUN → HALTED when the accepted instruction has stat ≠ AOK.
  - HALTED → RUN only on flush_i.
  - Reset → RUN.
- in_ready = rst && !flush_i && state==RUN && (!out_valid || out_ready).
- Accept = in_valid && in_ready. On accept the output register loads and out_valid=1. Otherwise, if out_ready, out_valid goes to 0.

## Timing
- Latency: 1 cycle, accept edge to registered outputs. Throughput 1/cycle while out_ready=1.
- Outputs hold stable while out_valid && !out_ready.
- Priority: reset > flush > accept/drain.
- Flush at the edge: out_valid=0, state=RUN, no accept that cycle.
- Reset values: out_valid 0, state RUN, halted_o 0, stat_o 0, all data outputs 0. in_ready is 0 while rst==0.
- Reset mid-stream discards the held instruction. The first accept can occur in the cycle after rst returns high.
- A HALT/INS instruction remains presented (out_valid=1) until consumed. After it is consumed, out_valid=0 and in_ready=0 until flush_i.
- srcA_o/srcB_o track inst_i combinationally, independent of handshake.

## Test plan
- Reset: drive rst=0 for 2 cycles with in_valid=1 → out_valid=0, in_ready=0, all outputs 0. After release, accept at pc 0x0010 inst 0x30F2_7856_3412 (irmovl) → rA_o=F, rB_o=2, valC_o=0x12345678, valP_o=0x0016, stat AOK.
- Length/wrap: rmmovl at pc 0xFFFE → valP_o=0x0004. call 0x80_00100000 at pc 0x0020 → valC_o=0x00001000, valP_o=0x0025, srcB_o=4.
- Backpressure: stream 3 instructions with out_ready low for 2 cycles → in_ready=0 and outputs frozen. No instruction is lost or duplicated.
- Invalid: inst 0x61 (opl ifun 1, rA=F rB=F)… then 0xC0 → stat INS, valP_o=pc+1, halted_o=1. Subsequent in_valid is ignored.
- HALT then flush: accept 0x00 → stat HLT, halted_o=1. Assert flush_i for one cycle → out_valid=0, halted_o=0. The next nop is accepted one cycle later.
- Operand forcing: pushl rA=3 (0xA03F) with valA_i=0xDEADBEEF, valB_i=0x100 → valA_o=0xDEADBEEF, valB_o=0x100. jxx → valA_o=valB_o=0.

Source files
------------

// File: rtl/id_stage_pipe.sv
// Y86 decode stage with a registered, valid/ready output slot.
// Splits the fetched bytes into fields, extracts valC, computes valP,
// drives register-file read IDs, classifies status and stops intake
// after HALT or an invalid instruction until a flush.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; a producer holds its payload stable while valid && !ready,
// and ready never depends on valid.
module id_stage_pipe #(
  parameter int WORD_W = 32,
  parameter int PC_W   = 16,
  parameter int INST_W = 16 + WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [INST_W-1:0] inst_i,
  output logic [3:0]        srcA_o,
  output logic [3:0]        srcB_o,
  input  logic [WORD_W-1:0] valA_i,
  input  logic [WORD_W-1:0] valB_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        icode_o,
  output logic [3:0]        ifun_o,
  output logic [3:0]        rA_o,
  output logic [3:0]        rB_o,
  output logic [WORD_W-1:0] valC_o,
  output logic [PC_W-1:0]   valP_o,
  output logic [WORD_W-1:0] valA_o,
  output logic [WORD_W-1:0] valB_o,
  output logic [1:0]        stat_o,
  output logic              halted_o
);

  localparam int N = WORD_W / 8;

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_INS = 2'd2;

  localparam logic [3:0] REG_NONE = 4'hF;
  localparam logic [3:0] REG_ESP  = 4'h4;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t state, state_nxt;

  // Raw fields of byte0/byte1
  logic [3:0] icode, ifun, ra, rb;
  assign icode = inst_i[INST_W-1  -: 4];
  assign ifun  = inst_i[INST_W-5  -: 4];
  assign ra    = inst_i[INST_W-9  -: 4];
  assign rb    = inst_i[INST_W-13 -: 4];

  logic [PC_W-1:0]   len;
  logic              has_regs;
  logic              c_at2;   // valC starts at byte 2
  logic              c_at1;   // valC starts at byte 1
  logic              icode_bad;
  logic              ifun_bad;
  logic              reg_bad;
  logic              ins;
  logic [1:0]        stat_d;
  logic [PC_W-1:0]   valp_d;
  logic [WORD_W-1:0] valc_d;
  logic [3:0]        ra_d, rb_d;
  logic [WORD_W-1:0] vala_d, valb_d;
  logic              accept;

  // Instruction length, layout and function-code legality per icode
  always_comb begin
    len       = PC_W'(1);
    has_regs  = 1'b0;
    c_at2     = 1'b0;
    c_at1     = 1'b0;
    icode_bad = 1'b0;
    ifun_bad  = (ifun != 4'h0);
    case (icode)
      4'h0, 4'h1, 4'h9: len = PC_W'(1);
      4'h2: begin
        len      = PC_W'(2);
        has_regs = 1'b1;
        ifun_bad = (ifun > 4'd6);
      end
      4'h6: begin
        len      = PC_W'(2);
        has_regs = 1'b1;
        ifun_bad = (ifun > 4'd3);
      end
      4'hA, 4'hB: begin
        len      = PC_W'(2);
        has_regs = 1'b1;
      end
      4'h3, 4'h4, 4'h5: begin
        len      = PC_W'(2 + N);
        has_regs = 1'b1;
        c_at2    = 1'b1;
      end
      4'h7: begin
        len      = PC_W'(1 + N);
        c_at1    = 1'b1;
        ifun_bad = (ifun > 4'd6);
      end
      4'h8: begin
        len      = PC_W'(1 + N);
        c_at1    = 1'b1;
      end
      default: icode_bad = 1'b1;
    endcase
  end

  // Little-endian constant extraction
  always_comb begin
    valc_d = '0;
    for (int i = 0; i < N; i++) begin
      if (c_at2)
        valc_d[8*i +: 8] = inst_i[INST_W-1-8*(2+i) -: 8];
      else if (c_at1)
        valc_d[8*i +: 8] = inst_i[INST_W-1-8*(1+i) -: 8];
    end
  end

  // Register fields, status and next PC
  always_comb begin
    ra_d    = has_regs ? ra : REG_NONE;
    rb_d    = has_regs ? rb : REG_NONE;
    // 0xF means "no register" and is legal; 8..0xE name nothing
    reg_bad = has_regs && (((ra >= 4'd8) && (ra != REG_NONE)) ||
                           ((rb >= 4'd8) && (rb != REG_NONE)));
    ins     = icode_bad || ifun_bad || reg_bad;
    if (ins)
      stat_d = STAT_INS;
    else if (icode == 4'h0)
      stat_d = STAT_HLT;
    else
      stat_d = STAT_AOK;
    valp_d  = pc_i + (ins ? PC_W'(1) : len);
  end

  // Register-file read IDs, independent of the handshake
  always_comb begin
    srcA_o = REG_NONE;
    srcB_o = REG_NONE;
    case (icode)
      4'h2, 4'h4, 4'h6, 4'hA: srcA_o = ra;
      4'h9, 4'hB:             srcA_o = REG_ESP;
      default:                srcA_o = REG_NONE;
    endcase
    case (icode)
      4'h4, 4'h5, 4'h6:       srcB_o = rb;
      4'h8, 4'h9, 4'hA, 4'hB: srcB_o = REG_ESP;
      default:                srcB_o = REG_NONE;
    endcase
    vala_d = (srcA_o == REG_NONE) ? '0 : valA_i;
    valb_d = (srcB_o == REG_NONE) ? '0 : valB_i;
  end

  assign in_ready = rst && !flush_i && (state == RUN) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign halted_o = (state == HALTED);

  // Next state: flush always returns to RUN; a non-AOK accept stops intake
  always_comb begin
    state_nxt = state;
    if (flush_i)
      state_nxt = RUN;
    else if (accept && (stat_d != STAT_AOK))
      state_nxt = HALTED;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst)
      state <= RUN;
    else
      state <= state_nxt;
  end

  // Output slot: reset clears, flush empties, accept loads, consume drains
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      icode_o   <= '0;
      ifun_o    <= '0;
      rA_o      <= '0;
      rB_o      <= '0;
      valC_o    <= '0;
      valP_o    <= '0;
      valA_o    <= '0;
      valB_o    <= '0;
      stat_o    <= STAT_AOK;
    end else if (flush_i) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      icode_o   <= icode;
      ifun_o    <= ifun;
      rA_o      <= ra_d;
      rB_o      <= rb_d;
      valC_o    <= valc_d;
      valP_o    <= valp_d;
      valA_o    <= vala_d;
      valB_o    <= valb_d;
      stat_o    <= stat_d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: directed scenarios followed by randomized
// traffic, checked against a decode model and an expected-output queue.
module tb_id_stage_pipe;

  localparam int WORD_W = 32;
  localparam int PC_W   = 16;
  localparam int INST_W = 16 + WORD_W;
  localparam int N      = WORD_W / 8;

  logic              clk;
  logic              rst;
  logic              flush_i;
  logic              in_valid;
  logic              in_ready;
  logic [PC_W-1:0]   pc_i;
  logic [INST_W-1:0] inst_i;
  logic [3:0]        srcA_o, srcB_o;
  logic [WORD_W-1:0] valA_i, valB_i;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        icode_o, ifun_o, rA_o, rB_o;
  logic [WORD_W-1:0] valC_o;
  logic [PC_W-1:0]   valP_o;
  logic [WORD_W-1:0] valA_o, valB_o;
  logic [1:0]        stat_o;
  logic              halted_o;

  id_stage_pipe #(.WORD_W(WORD_W), .PC_W(PC_W), .INST_W(INST_W)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .in_valid(in_valid), .in_ready(in_ready),
    .pc_i(pc_i), .inst_i(inst_i),
    .srcA_o(srcA_o), .srcB_o(srcB_o),
    .valA_i(valA_i), .valB_i(valB_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .icode_o(icode_o), .ifun_o(ifun_o), .rA_o(rA_o), .rB_o(rB_o),
    .valC_o(valC_o), .valP_o(valP_o),
    .valA_o(valA_o), .valB_o(valB_o),
    .stat_o(stat_o), .halted_o(halted_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic [3:0]        icode;
    logic [3:0]        ifun;
    logic [3:0]        ra;
    logic [3:0]        rb;
    logic [WORD_W-1:0] valc;
    logic [PC_W-1:0]   valp;
    logic [WORD_W-1:0] vala;
    logic [WORD_W-1:0] valb;
    logic [1:0]        stat;
  } pkt_t;

  pkt_t exp_q[$];
  bit   model_halted;
  int   n_checks;
  int   n_pass;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp)
      n_pass++;
    else
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic int ins_len(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:       return 1;
      4'h2, 4'h6, 4'hA, 4'hB: return 2;
      4'h3, 4'h4, 4'h5:       return 2 + N;
      4'h7, 4'h8:             return 1 + N;
      default:                return 0;
    endcase
  endfunction

  function automatic logic [7:0] byte_at(input logic [INST_W-1:0] inst, input int k);
    logic [INST_W-1:0] t;
    t = inst >> (INST_W - 8*(k+1));
    return t[7:0];
  endfunction

  function automatic logic [3:0] ref_src_a(input logic [INST_W-1:0] inst);
    logic [7:0] b0, b1;
    b0 = byte_at(inst, 0);
    b1 = byte_at(inst, 1);
    if (b0[7:4] inside {4'h2, 4'h4, 4'h6, 4'hA}) return b1[7:4];
    if (b0[7:4] inside {4'h9, 4'hB})             return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] ref_src_b(input logic [INST_W-1:0] inst);
    logic [7:0] b0, b1;
    b0 = byte_at(inst, 0);
    b1 = byte_at(inst, 1);
    if (b0[7:4] inside {4'h4, 4'h5, 4'h6})       return b1[3:0];
    if (b0[7:4] inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic pkt_t model(input logic [PC_W-1:0] pc, input logic [INST_W-1:0] inst,
                                 input logic [WORD_W-1:0] va, input logic [WORD_W-1:0] vb);
    pkt_t       p;
    logic [7:0] b0, b1;
    int         l, first;
    bit         regs, bad;
    b0     = byte_at(inst, 0);
    b1     = byte_at(inst, 1);
    l      = ins_len(b0[7:4]);
    regs   = (l == 2) || (l == 2 + N);
    p.icode = b0[7:4];
    p.ifun  = b0[3:0];
    p.ra    = regs ? b1[7:4] : 4'hF;
    p.rb    = regs ? b1[3:0] : 4'hF;
    first  = (p.icode inside {4'h3, 4'h4, 4'h5}) ? 2 :
             (p.icode inside {4'h7, 4'h8}) ? 1 : -1;
    p.valc = '0;
    if (first >= 0)
      for (int i = 0; i < N; i++)
        p.valc = p.valc | (WORD_W'(byte_at(inst, first + i)) << (8*i));
    bad = (l == 0)
       || (p.ifun != 0 && !(p.icode inside {4'h2, 4'h6, 4'h7}))
       || ((p.icode inside {4'h2, 4'h7}) && p.ifun > 6)
       || (p.icode == 4'h6 && p.ifun > 3)
       || (regs && ((b1[7:4] inside {[4'h8:4'hE]}) || (b1[3:0] inside {[4'h8:4'hE]})));
    p.stat = bad ? 2'd2 : (p.icode == 4'h0) ? 2'd1 : 2'd0;
    p.valp = PC_W'(int'(pc) + (bad ? 1 : l));
    p.vala = (ref_src_a(inst) == 4'hF) ? '0 : va;
    p.valb = (ref_src_b(inst) == 4'hF) ? '0 : vb;
    return p;
  endfunction

  // ---------------- driver ----------------
  // One clock: check presented outputs, apply inputs, check the
  // combinational side, then advance the model to the coming edge.
  task automatic drive_cycle(input bit r, input bit fl, input bit iv,
                             input logic [PC_W-1:0] pc, input logic [INST_W-1:0] inst,
                             input logic [WORD_W-1:0] va, input logic [WORD_W-1:0] vb,
                             input bit ordy);
    pkt_t p;
    bit   exp_rdy;
    @(negedge clk);
    check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
    check("halted", 64'(halted_o), 64'(model_halted));
    if (exp_q.size() != 0) begin
      p = exp_q[0];
      check("fields", 64'({icode_o, ifun_o, rA_o, rB_o, stat_o}),
                      64'({p.icode, p.ifun, p.ra, p.rb, p.stat}));
      check("valC", 64'(valC_o), 64'(p.valc));
      check("valP", 64'(valP_o), 64'(p.valp));
      check("valA", 64'(valA_o), 64'(p.vala));
      check("valB", 64'(valB_o), 64'(p.valb));
    end
    rst       = r;
    flush_i   = fl;
    in_valid  = iv;
    pc_i      = pc;
    inst_i    = inst;
    valA_i    = va;
    valB_i    = vb;
    out_ready = ordy;
    #1;
    exp_rdy = r && !fl && !model_halted && (exp_q.size() == 0 || ordy);
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    check("srcA", 64'(srcA_o), 64'(ref_src_a(inst)));
    check("srcB", 64'(srcB_o), 64'(ref_src_b(inst)));
    if (!r || fl) begin
      exp_q.delete();
      model_halted = 1'b0;
    end else begin
      if (exp_q.size() != 0 && ordy) void'(exp_q.pop_front());
      if (iv && exp_rdy) begin
        p = model(pc, inst, va, vb);
        exp_q.push_back(p);
        if (p.stat != 2'd0) model_halted = 1'b1;
      end
    end
  endtask

  task automatic send(input logic [PC_W-1:0] pc, input logic [INST_W-1:0] inst, input bit ordy);
    drive_cycle(1'b1, 1'b0, 1'b1, pc, inst, WORD_W'($urandom), WORD_W'($urandom), ordy);
  endtask

  task automatic idle(input bit fl);
    drive_cycle(1'b1, fl, 1'b0, '0, 48'h1000_0000_0000, '0, '0, 1'b1);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [INST_W-1:0] inst;
    logic [3:0]        ic, fn, ra, rb;
    bit                r, fl;
    n_checks     = 0;
    n_pass       = 0;
    model_halted = 1'b0;
    rst          = 1'b0;
    flush_i      = 1'b0;
    in_valid     = 1'b1;
    out_ready    = 1'b1;
    pc_i         = '0;
    inst_i       = 48'h30F2_7856_3412;
    valA_i       = '0;
    valB_i       = '0;
    @(posedge clk);

    // Reset held with traffic offered
    drive_cycle(1'b0, 1'b0, 1'b1, 16'h0010, 48'h30F2_7856_3412, 32'h1, 32'h2, 1'b1);
    drive_cycle(1'b0, 1'b0, 1'b1, 16'h0010, 48'h30F2_7856_3412, 32'h1, 32'h2, 1'b1);
    settle();
    check("rst_outputs", 64'({out_valid, halted_o, stat_o, icode_o, ifun_o, rA_o, rB_o, valP_o}), 64'h0);
    check("rst_data", 64'({valC_o, valA_o | valB_o}), 64'h0);

    // irmovl right after release
    send(16'h0010, 48'h30F2_7856_3412, 1'b1);
    settle();
    check("irmovl_regs", 64'({rA_o, rB_o, stat_o}), 64'({4'hF, 4'h2, 2'd0}));
    check("irmovl_valC", 64'(valC_o), 64'h1234_5678);
    check("irmovl_valP", 64'(valP_o), 64'h0016);

    // Length and PC wrap
    send(16'hFFFE, 48'h4012_0000_0000, 1'b1);
    settle();
    check("rmmovl_wrap", 64'(valP_o), 64'h0004);
    send(16'h0020, 48'h8000_1000_0000, 1'b1);
    check("call_srcB", 64'(srcB_o), 64'h4);
    settle();
    check("call_valC", 64'(valC_o), 64'h0000_1000);
    check("call_valP", 64'(valP_o), 64'h0025);

    // Backpressure: three instructions, consumer stalls two cycles
    send(16'h0100, 48'h6001_0000_0000, 1'b1);
    send(16'h0102, 48'h2023_0000_0000, 1'b0);
    send(16'h0102, 48'h2023_0000_0000, 1'b0);
    send(16'h0102, 48'h2023_0000_0000, 1'b1);
    send(16'h0104, 48'h1000_0000_0000, 1'b1);
    idle(1'b0);

    // Operand forcing
    drive_cycle(1'b1, 1'b0, 1'b1, 16'h0200, 48'hA03F_0000_0000, 32'hDEAD_BEEF, 32'h0000_0100, 1'b1);
    settle();
    check("pushl_ops", 64'({valA_o, valB_o}), 64'hDEAD_BEEF_0000_0100);
    drive_cycle(1'b1, 1'b0, 1'b1, 16'h0202, 48'h7000_0010_0000, 32'h5555_AAAA, 32'h1234_4321, 1'b1);
    settle();
    check("jxx_ops", 64'({valA_o, valB_o}), 64'h0);

    // Invalid instruction stops intake
    send(16'h0300, 48'h61FF_0000_0000, 1'b1);
    send(16'h0302, 48'hC000_0000_0000, 1'b1);
    settle();
    check("ins_stat", 64'({stat_o, halted_o}), 64'({2'd2, 1'b1}));
    check("ins_valP", 64'(valP_o), 64'h0303);
    for (int i = 0; i < 3; i++) send(16'h0303, 48'h1000_0000_0000, 1'b1);
    settle();
    check("ins_drained", 64'(out_valid), 64'h0);
    idle(1'b1);

    // HALT then flush, next nop accepted right after
    send(16'h0400, 48'h0000_0000_0000, 1'b1);
    settle();
    check("hlt_stat", 64'({stat_o, halted_o}), 64'({2'd1, 1'b1}));
    drive_cycle(1'b1, 1'b1, 1'b1, 16'h0401, 48'h1000_0000_0000, '0, '0, 1'b0);
    settle();
    check("flush_clears", 64'({out_valid, halted_o}), 64'h0);
    send(16'h0401, 48'h1000_0000_0000, 1'b1);
    settle();
    check("nop_after_flush", 64'({out_valid, icode_o, valP_o}), 64'({1'b1, 4'h1, 16'h0402}));

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      ic = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 11)) : 4'($urandom_range(0, 15));
      fn = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) :
           ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 6)) : 4'h0;
      ra = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 7)) : 4'($urandom_range(0, 15));
      rb = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 7)) : 4'($urandom_range(0, 15));
      inst = {ic, fn, ra, rb, 32'($urandom)};
      r  = ($urandom_range(0, 79) != 0);
      fl = model_halted ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 39) == 0);
      drive_cycle(r, fl, ($urandom_range(0, 3) != 0), PC_W'($urandom), inst,
                  WORD_W'($urandom), WORD_W'($urandom), ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 3; i++) idle(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
